mf8_uart_tx: RTL and testbench

Hardware UART transmitter on the mf8 core's IO bus, directly downstream of the core's IO write port. It replaces bit-banged `UART_TXD`. Firmware writes bytes into a small FIFO, the block serialises them as 8N1 frames (or 8E1 frames when parity is enabled), and firmware polls a status register through `IO_RData`.

---
 rtl/mf8_uart_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_mf8_uart_tx.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mf8_uart_tx.sv
// mf8 IO-bus UART transmitter: byte FIFO feeding an 8N1 serialiser with a polled status register.
// Define MF8_UART_TX_PARITY_EN to add an even-parity bit and send 8E1 frames.
module mf8_uart_tx #(
    parameter int          CLK_DIV    = 104,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [5:0]  DATA_ADDR  = 6'h00,
    parameter logic [5:0]  STAT_ADDR  = 6'h01
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IO_Rd,
    input  logic       IO_Wr,
    input  logic [5:0] IO_Addr,
    input  logic [7:0] IO_WData,
    output logic [7:0] IO_RData,
    output logic       UART_TXD
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef MF8_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
`endif

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [BAUD_W-1:0] baud_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic              ovf_r;
`ifdef MF8_UART_TX_PARITY_EN
    logic              par_r;
`endif
    logic              full_s;
    logic              empty_s;
    logic              busy_s;
    logic              data_wr_s;
    logic              stat_wr_s;
    logic              push_s;
    logic              pop_s;
    logic              baud_wrap_s;
    logic              unused_s;

    assign unused_s    = IO_Rd;
    assign full_s      = (count_r == CNT_FULL);
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign busy_s      = (state_r != ST_IDLE);
    assign data_wr_s   = IO_Wr && (IO_Addr == DATA_ADDR);
    assign stat_wr_s   = IO_Wr && (IO_Addr == STAT_ADDR);
    assign push_s      = data_wr_s && !full_s;
    assign baud_wrap_s = (baud_r == BAUD_LAST);

    // Status read mux; only the status address returns anything non-zero.
    always_comb begin
        IO_RData = 8'h00;
        if (IO_Addr == STAT_ADDR) begin
            IO_RData = {4'b0000, ovf_r, busy_s, empty_s, full_s};
        end else begin
            IO_RData = 8'h00;
        end
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= IO_WData;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Overflow flag: a dropped byte sets it, a status write clears it, set wins.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_r <= 1'b0;
        end else if (data_wr_s && full_s) begin
            ovf_r <= 1'b1;
        end else if (stat_wr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a pop happens on every entry into START.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_nxt_s = ST_START;
                    pop_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_wrap_s) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_wrap_s && (bit_cnt_r == 3'd7)) begin
`ifdef MF8_UART_TX_PARITY_EN
                    state_nxt_s = ST_PARITY;
`else
                    state_nxt_s = ST_STOP;
`endif
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef MF8_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_wrap_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (baud_wrap_s && !empty_s) begin
                    state_nxt_s = ST_START;
                    pop_s       = 1'b1;
                end else if (baud_wrap_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pop_s       = 1'b0;
            end
        endcase
    end

    // Baud counter, bit counter and shift register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            baud_r    <= {BAUD_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef MF8_UART_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else if (pop_s) begin
            baud_r    <= {BAUD_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= mem_r[rd_ptr_r];
`ifdef MF8_UART_TX_PARITY_EN
            par_r     <= even_parity(mem_r[rd_ptr_r]);
`endif
        end else if (state_r == ST_IDLE) begin
            baud_r <= {BAUD_W{1'b0}};
        end else if (baud_wrap_s) begin
            baud_r <= {BAUD_W{1'b0}};
            if (state_r == ST_DATA) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end else begin
            baud_r <= baud_r + BAUD_W'(1);
        end
    end

    // Serial line, registered from the current state so it lags the FSM by one cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            UART_TXD <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE:   UART_TXD <= 1'b1;
                ST_START:  UART_TXD <= 1'b0;
                ST_DATA:   UART_TXD <= shift_r[0];
`ifdef MF8_UART_TX_PARITY_EN
                ST_PARITY: UART_TXD <= par_r;
`endif
                ST_STOP:   UART_TXD <= 1'b1;
                default:   UART_TXD <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mf8_uart_tx.sv
// Directed self-checking bench for mf8_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
module tb_mf8_uart_tx;

    localparam logic [5:0] DATA_A = 6'h00;
    localparam logic [5:0] STAT_A = 6'h01;
`ifdef MF8_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] A5_FRAME = 11'b10101001010;
`else
    localparam int NB = 10;
    localparam logic [10:0] A5_FRAME = 11'b01101001010;
`endif

    logic       CLK;
    logic       RST;
    logic       IO_Rd;
    logic       IO_Wr;
    logic [5:0] IO_Addr;
    logic [7:0] IO_WData;
    logic [7:0] IO_RData;
    logic       UART_TXD;

    int total;
    int bad;

    mf8_uart_tx #(
        .CLK_DIV    (4),
        .FIFO_DEPTH (4),
        .DATA_ADDR  (6'h00),
        .STAT_ADDR  (6'h01)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IO_Rd    (IO_Rd),
        .IO_Wr    (IO_Wr),
        .IO_Addr  (IO_Addr),
        .IO_WData (IO_WData),
        .IO_RData (IO_RData),
        .UART_TXD (UART_TXD)
    );

    always #5 CLK = ~CLK;

    // Expected line bits, index = bit time (start bit first).
    function automatic logic [10:0] build_frame(input logic [7:0] d);
`ifdef MF8_UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        IO_Addr  = a;
        IO_WData = d;
        IO_Wr    = 1'b1;
        step();
        IO_Wr    = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] v);
        IO_Wr   = 1'b0;
        IO_Addr = STAT_A;
        #1;
        v = IO_RData;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (UART_TXD === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Capture one frame, one sample per cycle; skip = start-bit cycles already elapsed.
    task automatic read_frame(input int skip, output logic [10:0] bits, output bit stable);
        int b;
        bits   = '0;
        stable = 1'b1;
        for (int i = skip; i < NB * 4; i++) begin
            b = i / 4;
            if (i == skip || (i % 4) == 0) begin
                bits[b] = UART_TXD;
            end else if (UART_TXD !== bits[b]) begin
                stable = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [7:0] st;
        int         lows;
        RST = 1'b1;
        repeat (2) step();
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL reset_txd: got %b want 1", UART_TXD);
        end
        RST = 1'b0;
        step();
        read_status(st);
        total++;
        if (st !== 8'h02) begin
            bad++;
            $display("FAIL reset_status: got %h want 02", st);
        end
        IO_Addr = DATA_A;
        #1;
        total++;
        if (IO_RData !== 8'h00) begin
            bad++;
            $display("FAIL read_data_addr: got %h want 00", IO_RData);
        end
        IO_Addr = 6'h2A;
        #1;
        total++;
        if (IO_RData !== 8'h00) begin
            bad++;
            $display("FAIL read_other_addr: got %h want 00", IO_RData);
        end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (UART_TXD !== 1'b1) lows++;
            step();
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL reset_idle_line: low cycles %0d want 0", lows);
        end
    endtask

    task automatic test_single();
        logic [7:0]  st;
        logic [10:0] fr;
        bit          stb;
        io_write(DATA_A, 8'hA5);
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL lat_edge_n: got %b want 1", UART_TXD);
        end
        step();
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL lat_edge_n1: got %b want 1", UART_TXD);
        end
        step();
        total++;
        if (UART_TXD !== 1'b0) begin
            bad++;
            $display("FAIL lat_edge_n2: got %b want 0", UART_TXD);
        end
        read_status(st);
        total++;
        if (st !== 8'h06) begin
            bad++;
            $display("FAIL single_busy_status: got %h want 06", st);
        end
        read_frame(0, fr, stb);
        total++;
        if (fr !== A5_FRAME) begin
            bad++;
            $display("FAIL single_a5_frame: got %b want %b", fr, A5_FRAME);
        end
        total++;
        if (stb !== 1'b1) begin
            bad++;
            $display("FAIL single_bit_width: bits not stable for 4 cycles");
        end
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL single_after_stop: got %b want 1", UART_TXD);
        end
        read_status(st);
        total++;
        if (st !== 8'h02) begin
            bad++;
            $display("FAIL single_end_status: got %h want 02", st);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [5];
        logic [7:0]  st;
        logic [10:0] fr;
        bit          stb;
        bytes = '{8'h3C, 8'h81, 8'h7E, 8'h01, 8'hC3};
        for (int i = 0; i < 5; i++) begin
            io_write(DATA_A, bytes[i]);
        end
        read_status(st);
        total++;
        if (st !== 8'h05) begin
            bad++;
            $display("FAIL b2b_full_status: got %h want 05", st);
        end
        for (int i = 0; i < 5; i++) begin
            read_frame((i == 0) ? 2 : 0, fr, stb);
            total++;
            if (fr !== build_frame(bytes[i]) || stb !== 1'b1) begin
                bad++;
                $display("FAIL b2b_frame%0d: got %b stable %b want %b", i, fr, stb, build_frame(bytes[i]));
            end
        end
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: got %b want 1", UART_TXD);
        end
        read_status(st);
        total++;
        if (st !== 8'h02) begin
            bad++;
            $display("FAIL b2b_end_status: got %h want 02", st);
        end
    endtask

    task automatic test_overflow();
        logic [7:0]  bytes [6];
        logic [7:0]  st;
        logic [10:0] fr;
        bit          stb;
        int          lows;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) begin
            io_write(DATA_A, bytes[i]);
        end
        read_status(st);
        total++;
        if (st !== 8'h0D) begin
            bad++;
            $display("FAIL ovf_set_status: got %h want 0D", st);
        end
        io_write(STAT_A, 8'hFF);
        read_status(st);
        total++;
        if (st !== 8'h05) begin
            bad++;
            $display("FAIL ovf_clear_status: got %h want 05", st);
        end
        for (int i = 0; i < 5; i++) begin
            read_frame((i == 0) ? 4 : 0, fr, stb);
            total++;
            if (fr !== build_frame(bytes[i]) || stb !== 1'b1) begin
                bad++;
                $display("FAIL ovf_frame%0d: got %b stable %b want %b", i, fr, stb, build_frame(bytes[i]));
            end
        end
        lows = 0;
        for (int i = 0; i < 3 * NB * 4; i++) begin
            if (UART_TXD !== 1'b1) lows++;
            step();
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL ovf_dropped_byte_sent: low cycles %0d want 0", lows);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] st;
        int         lows;
        io_write(DATA_A, 8'h00);
        io_write(DATA_A, 8'h5A);
        io_write(DATA_A, 8'hC3);
        repeat (17) step();
        total++;
        if (UART_TXD !== 1'b0) begin
            bad++;
            $display("FAIL mid_data_bit3: got %b want 0", UART_TXD);
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if (UART_TXD !== 1'b1) begin
            bad++;
            $display("FAIL mid_async_reset: got %b want 1", UART_TXD);
        end
        repeat (3) step();
        RST = 1'b0;
        read_status(st);
        total++;
        if (st !== 8'h02) begin
            bad++;
            $display("FAIL mid_post_status: got %h want 02", st);
        end
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (UART_TXD !== 1'b1) lows++;
            step();
        end
        total++;
        if (lows !== 0) begin
            bad++;
            $display("FAIL mid_no_frames: low cycles %0d want 0", lows);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  bytes [9];
        logic [7:0]  st;
        logic [10:0] fr;
        bit          stb;
        bit          ok;
        bytes = '{8'h00, 8'hFF, 8'h5A, 8'h96, 8'h0F, 8'hF0, 8'h69, 8'h12, 8'h80};
        for (int i = 0; i < 9; i++) begin
            io_write(DATA_A, bytes[i]);
            wait_start(ok);
            total++;
            if (ok !== 1'b1) begin
                bad++;
                $display("FAIL wrap_start%0d: got no start bit want start within 20 cycles", i);
            end else begin
                read_frame(0, fr, stb);
                total++;
                if (fr !== build_frame(bytes[i]) || stb !== 1'b1) begin
                    bad++;
                    $display("FAIL wrap_frame%0d: got %b stable %b want %b", i, fr, stb, build_frame(bytes[i]));
                end
            end
        end
        read_status(st);
        total++;
        if (st !== 8'h02) begin
            bad++;
            $display("FAIL wrap_end_status: got %h want 02", st);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        CLK      = 1'b0;
        RST      = 1'b1;
        IO_Rd    = 1'b0;
        IO_Wr    = 1'b0;
        IO_Addr  = 6'h00;
        IO_WData = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
